// File: rtl/psram_hbus_ctrl.sv
// Single-word HyperBus controller for the GW1NR-9 embedded PSRAM: power-up wait, optional
// CR0 write (compiled in with PSRAM_CR0_INIT_EN), and 16-bit read/write transactions.
module psram_hbus_ctrl #(
   parameter int          INIT_CYCLES = 11138,
   parameter int          LATENCY     = 6,
   parameter int          RD_DELAY    = 2,
   parameter int          RECOVERY    = 6,
   parameter logic [15:0] CR0_VALUE   = 16'h8F1F
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [21:0] req_addr,
   input  logic [15:0] req_wdata,
   input  logic [1:0]  req_ben,
   output logic        rd_valid,
   output logic [15:0] rd_data,
   output logic        init_done,
   output logic        psram_cs_n,
   output logic        psram_ck,
   output logic [7:0]  psram_dq_o,
   output logic        psram_dq_oe,
   input  logic [7:0]  psram_dq_i,
   output logic        psram_rwds_o,
   output logic        psram_rwds_oe
);

   localparam logic [15:0] INIT_LAST   = 16'(INIT_CYCLES - 1);
   localparam logic [15:0] LAT_LAST    = 16'(4 * LATENCY - 3);
   localparam logic [15:0] RDW_LAST    = 16'(RD_DELAY - 1);
   localparam logic [15:0] REC_LAST    = 16'(RECOVERY - 1);
   localparam logic [47:0] CFG_CA_WORD = 48'h6000_0100_0000;

   typedef enum logic [3:0] {
      S_INIT_WAIT,
      S_CFG_CA,
      S_CFG_DATA,
      S_RECOVER,
      S_IDLE,
      S_CA,
      S_LAT,
      S_WDATA,
      S_RDWAIT,
      S_RDATA
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] last;
   logic        accept;
   logic        ck_q, ck_d;
   logic        init_done_q, init_done_d;
   logic        rd_valid_q, rd_valid_d;
   logic [15:0] rd_data_q, rd_data_d;
   logic [7:0]  cap_hi_q, cap_hi_d;
   logic        we_q, we_d;
   logic [21:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [1:0]  ben_q, ben_d;
   logic [47:0] ca_word;

   function automatic logic [7:0] ca_byte(input logic [47:0] w, input logic [2:0] idx);
      case (idx)
         3'd0:    ca_byte = w[47:40];
         3'd1:    ca_byte = w[39:32];
         3'd2:    ca_byte = w[31:24];
         3'd3:    ca_byte = w[23:16];
         3'd4:    ca_byte = w[15:8];
         default: ca_byte = w[7:0];
      endcase
   endfunction

   function automatic logic cs_active(input state_t s);
      cs_active = (s != S_INIT_WAIT) && (s != S_RECOVER) && (s != S_IDLE);
   endfunction

   // Read, memory space, linear burst; word address split into row and column parts.
   assign ca_word = {~we_q, 1'b0, 1'b1, 10'b0, addr_q[21:3], 13'b0, addr_q[2:0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      accept  = 1'b0;
      last    = 16'd1;
      case (state_q)
         S_INIT_WAIT:    last = INIT_LAST;
         S_CFG_CA, S_CA: last = 16'd5;
         S_LAT:          last = LAT_LAST;
         S_RDWAIT:       last = RDW_LAST;
         S_RECOVER:      last = REC_LAST;
         default:        last = 16'd1;
      endcase

      if (state_q == S_IDLE) begin
         cnt_d = '0;
         if (req_valid) begin
            accept  = 1'b1;
            state_d = S_CA;
         end
      end else if (cnt_q == last) begin
         cnt_d = '0;
         case (state_q)
`ifdef PSRAM_CR0_INIT_EN
            S_INIT_WAIT: state_d = S_CFG_CA;
`else
            S_INIT_WAIT: state_d = S_RECOVER;
`endif
            S_CFG_CA:    state_d = S_CFG_DATA;
            S_CA:        state_d = S_LAT;
            S_LAT:       state_d = we_q ? S_WDATA : S_RDWAIT;
            S_RDWAIT:    state_d = S_RDATA;
            S_RECOVER:   state_d = S_IDLE;
            default:     state_d = S_RECOVER;
         endcase
      end

      // CK starts high on the first CS#-low cycle; even phase lengths bring it back to 0.
      ck_d        = cs_active(state_d) ? ~ck_q : 1'b0;
      init_done_d = init_done_q | (state_d == S_IDLE);

      cap_hi_d   = ((state_q == S_RDATA) && (cnt_q == 16'd0)) ? psram_dq_i : cap_hi_q;
      rd_valid_d = (state_q == S_RDATA) && (cnt_q == 16'd1);
      rd_data_d  = rd_valid_d ? {cap_hi_q, psram_dq_i} : rd_data_q;

      we_d    = accept ? req_we    : we_q;
      addr_d  = accept ? req_addr  : addr_q;
      wdata_d = accept ? req_wdata : wdata_q;
      ben_d   = accept ? req_ben   : ben_q;
   end

   always_comb begin
      psram_dq_oe   = 1'b0;
      psram_dq_o    = 8'h00;
      psram_rwds_oe = 1'b0;
      psram_rwds_o  = 1'b0;
      case (state_q)
         S_CFG_CA: begin
            psram_dq_oe = 1'b1;
            psram_dq_o  = ca_byte(CFG_CA_WORD, cnt_q[2:0]);
         end
         S_CFG_DATA: begin
            psram_dq_oe = 1'b1;
            psram_dq_o  = cnt_q[0] ? CR0_VALUE[7:0] : CR0_VALUE[15:8];
         end
         S_CA: begin
            psram_dq_oe = 1'b1;
            psram_dq_o  = ca_byte(ca_word, cnt_q[2:0]);
         end
         S_WDATA: begin
            // RWDS high masks the byte, so it carries the inverted byte enable.
            psram_dq_oe   = 1'b1;
            psram_dq_o    = cnt_q[0] ? wdata_q[7:0] : wdata_q[15:8];
            psram_rwds_oe = 1'b1;
            psram_rwds_o  = cnt_q[0] ? ~ben_q[0] : ~ben_q[1];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_INIT_WAIT;
         cnt_q       <= '0;
         ck_q        <= 1'b0;
         init_done_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ck_q        <= ck_d;
         init_done_q <= init_done_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
      end
   end

   always_ff @(posedge clk) begin
      cap_hi_q <= cap_hi_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ben_q    <= ben_d;
   end

   assign req_ready  = (state_q == S_IDLE);
   assign init_done  = init_done_q;
   assign rd_valid   = rd_valid_q;
   assign rd_data    = rd_data_q;
   assign psram_cs_n = ~cs_active(state_q);
   assign psram_ck   = ck_q;

endmodule

// File: tb/tb_psram_hbus_ctrl.sv
// Bench for psram_hbus_ctrl: directed and random transactions against a cycle-level bus model
// derived from the transaction rules, with a word-addressed memory model supplying read data.
module tb_psram_hbus_ctrl;

   localparam int          INIT_CYCLES = 120;
   localparam int          LATENCY     = 6;
   localparam int          RD_DELAY    = 2;
   localparam int          RECOVERY    = 6;
   localparam logic [15:0] CR0_VALUE   = 16'h8F1F;
   localparam int          LAT         = 4 * LATENCY - 2;
   localparam int          WR_LEN      = 6 + LAT + 2;
   localparam int          RD_LEN      = 6 + LAT + RD_DELAY + 2;
`ifdef PSRAM_CR0_INIT_EN
   localparam int          CFG_LEN     = 8;
`else
   localparam int          CFG_LEN     = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [21:0] req_addr;
   logic [15:0] req_wdata;
   logic [1:0]  req_ben;
   logic        rd_valid;
   logic [15:0] rd_data;
   logic        init_done;
   logic        psram_cs_n;
   logic        psram_ck;
   logic [7:0]  psram_dq_o;
   logic        psram_dq_oe;
   logic [7:0]  psram_dq_i;
   logic        psram_rwds_o;
   logic        psram_rwds_oe;

   always #5 clk = ~clk;

   psram_hbus_ctrl #(
      .INIT_CYCLES(INIT_CYCLES),
      .LATENCY    (LATENCY),
      .RD_DELAY   (RD_DELAY),
      .RECOVERY   (RECOVERY),
      .CR0_VALUE  (CR0_VALUE)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_ben      (req_ben),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .init_done    (init_done),
      .psram_cs_n   (psram_cs_n),
      .psram_ck     (psram_ck),
      .psram_dq_o   (psram_dq_o),
      .psram_dq_oe  (psram_dq_oe),
      .psram_dq_i   (psram_dq_i),
      .psram_rwds_o (psram_rwds_o),
      .psram_rwds_oe(psram_rwds_oe)
   );

   int          vectors     = 0;
   int          miscompares = 0;
   int          cyc         = 0;
   int          last_end    = 0;
   int          acc;
   int          prev_end;
   logic [15:0] last_rd     = 16'h0000;
   logic [15:0] mem [int];
   logic [21:0] addrs [4]   = '{22'h000000, 22'h012345, 22'h3FFFFF, 22'h000007};

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [15:0] obs_bus();
      return {psram_cs_n, psram_ck, psram_dq_oe, psram_dq_o, psram_rwds_oe, psram_rwds_o,
              req_ready, init_done, rd_valid};
   endfunction

   function automatic logic [15:0] pack(input logic cs, input logic ck, input logic oe,
                                        input logic [7:0] dq, input logic roe, input logic r,
                                        input logic rdy, input logic done, input logic rv);
      return {cs, ck, oe, dq, roe, r, rdy, done, rv};
   endfunction

   function automatic logic [15:0] idle_bus(input logic rdy, input logic done);
      return pack(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, rdy, done, 1'b0);
   endfunction

   // Called in the first cycle with reset low; walks power-up wait, config and recovery.
   task automatic init_seq();
      longint unsigned cfg;
      logic [15:0]     e;
      int              k;
      cfg = 64'h6000_0100_0000 * 64'd65536 + 64'(CR0_VALUE);
      for (int j = 0; j < INIT_CYCLES + CFG_LEN + RECOVERY; j++) begin
         k = j - INIT_CYCLES + 1;
         if (j >= INIT_CYCLES && k <= CFG_LEN)
            e = pack(1'b0, k[0], 1'b1, 8'((cfg >> (8 * (8 - k))) & 64'd255), 1'b0, 1'b0,
                     1'b0, 1'b0, 1'b0);
         else
            e = idle_bus(1'b0, 1'b0);
         chk("init_bus", 32'(obs_bus()), 32'(e));
         psram_dq_i = 8'($urandom);
         tick();
      end
      chk("init_done_ready", 32'({init_done, req_ready}), 32'd3);
   endtask

   task automatic txn(input logic we, input logic [21:0] addr, input logic [15:0] wd,
                      input logic [1:0] ben, input logic hold, output int acc_cyc);
      int              waited;
      int              len;
      int              j;
      logic [15:0]     rdv;
      logic [15:0]     t;
      logic [15:0]     e;
      longint unsigned ca;
      string           tag;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      req_ben   = ben;
      waited    = 0;
      while (!req_ready && waited < 200) begin
         tick();
         waited++;
      end
      acc_cyc = cyc;
      if (!req_ready) begin
         chk("accept_timeout", 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         return;
      end
      chk("accept_bus", 32'(obs_bus()), 32'(idle_bus(1'b1, 1'b1)));
      chk("rd_data_hold", 32'(rd_data), 32'(last_rd));

      if (!mem.exists(int'(addr))) mem[int'(addr)] = 16'($urandom);
      rdv = mem[int'(addr)];
      if (we) begin
         t = rdv;
         if (ben[1]) t[15:8] = wd[15:8];
         if (ben[0]) t[7:0]  = wd[7:0];
         mem[int'(addr)] = t;
      end

      len = we ? WR_LEN : RD_LEN;
      tag = we ? "wr_bus" : "rd_bus";
      ca  = (we ? 64'd0 : (64'd1 << 47)) + (64'd1 << 45)
            + 64'(addr / 22'd8) * 64'd65536 + 64'(addr % 22'd8);

      for (int i = 1; i <= len + RECOVERY; i++) begin
         tick();
         req_valid  = hold;
         req_we     = 1'($urandom);
         req_addr   = 22'($urandom);
         req_wdata  = 16'($urandom);
         req_ben    = 2'($urandom);
         psram_dq_i = 8'($urandom);
         if (!we && i == 6 + LAT + RD_DELAY + 1) psram_dq_i = rdv[15:8];
         if (!we && i == 6 + LAT + RD_DELAY + 2) psram_dq_i = rdv[7:0];

         if (i > len)
            e = pack(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, (!we && i == len + 1));
         else if (i <= 6)
            e = pack(1'b0, i[0], 1'b1, 8'((ca >> (8 * (6 - i))) & 64'd255), 1'b0, 1'b0,
                     1'b0, 1'b1, 1'b0);
         else if (we && i > 6 + LAT) begin
            j = i - 6 - LAT;
            e = pack(1'b0, i[0], 1'b1, (j == 1) ? wd[15:8] : wd[7:0], 1'b1,
                     (j == 1) ? ~ben[1] : ~ben[0], 1'b0, 1'b1, 1'b0);
         end else
            e = pack(1'b0, i[0], 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         chk(tag, 32'(obs_bus()), 32'(e));

         if (!we && i == len + 1) begin
            chk("rd_data", 32'(rd_data), 32'(rdv));
            last_rd = rdv;
         end
      end
      req_valid = hold;
      last_end  = cyc;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_ben    = '0;
      psram_dq_i = '0;

      // Reset values while reset is held.
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("reset_bus", 32'(obs_bus()), 32'(idle_bus(1'b0, 1'b0)));
         chk("reset_rd_data", 32'(rd_data), 32'd0);
      end
      reset = 1'b0;
      init_seq();

      // Directed write, then reads of a preloaded word and of the partially written word.
      txn(1'b1, 22'h012345, 16'hA55A, 2'b10, 1'b0, acc);
      mem[0] = 16'hBEEF;
      txn(1'b0, 22'h000000, 16'h0000, 2'b11, 1'b0, acc);
      txn(1'b0, 22'h012345, 16'h0000, 2'b11, 1'b0, acc);

      // Random traffic over a small address set so reads hit earlier writes.
      for (int n = 0; n < 12; n++)
         txn(1'($urandom), addrs[$urandom_range(0, 3)], 16'($urandom), 2'($urandom), 1'b0, acc);

      // Back-to-back with req_valid held: each accept lands right after recovery ends.
      txn(1'b1, addrs[1], 16'($urandom), 2'b11, 1'b1, acc);
      for (int n = 0; n < 4; n++) begin
         prev_end = last_end;
         txn(1'(n % 2), addrs[n], 16'($urandom), 2'($urandom), 1'b1, acc);
         chk("b2b_accept", acc, prev_end + 1);
      end
      req_valid = 1'b0;

      // Reset during the latency phase of a read.
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = addrs[1];
      for (int w = 0; w < 200 && !req_ready; w++) tick();
      chk("midrd_accept", 32'(req_ready), 32'd1);
      for (int i = 0; i < 10; i++) begin
         tick();
         req_valid = 1'b0;
      end
      chk("midrd_in_lat", 32'({psram_cs_n, psram_dq_oe}), 32'd0);
      reset = 1'b1;
      tick();
      chk("midrd_reset_bus", 32'(obs_bus()), 32'(idle_bus(1'b0, 1'b0)));
      chk("midrd_rd_data", 32'(rd_data), 32'd0);
      reset   = 1'b0;
      last_rd = 16'h0000;
      init_seq();

      for (int n = 0; n < 4; n++)
         txn(1'(n < 2), addrs[3 - n], 16'($urandom), 2'b11, 1'b0, acc);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
